// File: rtl/mem_data_aligner_pkg.sv
// Shared core package: RV32I load/store width codes and M-stage bundle.
// Also consumed by the memory-enable decode.
package mem_data_aligner_pkg;

  localparam logic [2:0] F3_BYTE  = 3'b000;
  localparam logic [2:0] F3_HALF  = 3'b001;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_BYTEU = 3'b100;
  localparam logic [2:0] F3_HALFU = 3'b101;

  typedef struct packed {
    logic       valid;
    logic       load;
    logic       store;
    logic [2:0] funct3;
    logic [1:0] addr;
  } m_reg_t;

  // Reserved width codes fall through to word.
  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic w_half;
    logic w_word;
    w_half = (f3[1:0] == 2'b01);
    w_word = f3[1];
    return (w_half & a[0]) | (w_word & (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_data_aligner_load_extend.sv
// Combinational load lane select and sign/zero extension.
// Reserved width codes behave as LW.
module load_extend
  import mem_data_aligner_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word[7:0];
    unique case (addr)
      2'b00: w_byte = word[7:0];
      2'b01: w_byte = word[15:8];
      2'b10: w_byte = word[23:16];
      2'b11: w_byte = word[31:24];
      default: w_byte = word[7:0];
    endcase
  end

  assign w_half = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = word;
    unique case (1'b1)
      (funct3 == F3_BYTE):  result = {{24{w_byte[7]}}, w_byte};
      (funct3 == F3_BYTEU): result = {24'b0, w_byte};
      (funct3 == F3_HALF):  result = {{16{w_half[15]}}, w_half};
      (funct3 == F3_HALFU): result = {16'b0, w_half};
      default:              result = word;
    endcase
  end

endmodule

// File: rtl/mem_data_aligner.sv
// M-stage memory data aligner: store lane shift, load extract,
// alignment check and stall hold of the load result.
module mem_data_aligner
  import mem_data_aligner_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_funct3,
  input  logic [DWIDTH-1:0] ex_addr,
  input  logic [DWIDTH-1:0] ex_rs2_data,
  input  logic [DWIDTH-1:0] dmem_dout,
  output logic [DWIDTH-1:0] dmem_din,
  output logic [DWIDTH-1:0] m_load_data,
  output logic              m_load_valid,
  output logic              m_misaligned
);

  m_reg_t            r_m;
  logic              r_mis;
  logic [DWIDTH-1:0] r_hold;
  logic              r_hold_act;
  logic [DWIDTH-1:0] w_ext;
  logic              w_unused;

  assign w_unused = ^ex_addr[DWIDTH-1:2];

  always_comb begin
    dmem_din = ex_rs2_data;
    unique case (1'b1)
      (ex_funct3[1:0] == 2'b00):
        dmem_din = {24'b0, ex_rs2_data[7:0]}
                   << {ex_addr[1:0], 3'b000};
      (ex_funct3[1:0] == 2'b01):
        dmem_din = {16'b0, ex_rs2_data[15:0]}
                   << {ex_addr[1], 4'b0000};
      default:
        dmem_din = ex_rs2_data;
    endcase
  end

  load_extend u_load_extend (
    .funct3 (r_m.funct3),
    .addr   (r_m.addr),
    .word   (dmem_dout),
    .result (w_ext)
  );

  assign m_misaligned =
    r_m.valid & (r_m.load | r_m.store) & r_mis;
  assign m_load_valid = r_m.valid & r_m.load & ~r_mis;

  always_comb begin
    m_load_data = '0;
    if (m_load_valid)
      m_load_data = r_hold_act ? r_hold : w_ext;
  end

  // Hold captures once per stall; released on the first unstalled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m        <= '0;
      r_mis      <= 1'b0;
      r_hold     <= '0;
      r_hold_act <= 1'b0;
    end else if (!stall) begin
      r_m.valid  <= ex_valid & ~flush;
      r_m.load   <= ex_is_load;
      r_m.store  <= ex_is_store;
      r_m.funct3 <= ex_funct3;
      r_m.addr   <= ex_addr[1:0];
      r_mis      <= misaligned(ex_funct3, ex_addr[1:0]);
      r_hold_act <= 1'b0;
    end else if (!r_hold_act && m_load_valid) begin
      r_hold     <= w_ext;
      r_hold_act <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_data_aligner.sv
// Randomized + directed bench for mem_data_aligner.
// Reference model computes results from byte/half lane arithmetic.
module tb_mem_data_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic        ex_valid, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_rs2_data, dmem_dout;
  logic [31:0] dmem_din, m_load_data;
  logic        m_load_valid, m_misaligned;

  int n_tests = 0;
  int n_fail  = 0;

  bit          mv, mld, mst, hact;
  logic [2:0]  mf3;
  logic [1:0]  ma;
  logic [31:0] hval;

  logic [31:0] last_data, last_din;
  logic        last_valid, last_mis;

  always #5 clk = ~clk;

  mem_data_aligner #(.DWIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_is_load   (ex_is_load),
    .ex_is_store  (ex_is_store),
    .ex_funct3    (ex_funct3),
    .ex_addr      (ex_addr),
    .ex_rs2_data  (ex_rs2_data),
    .dmem_dout    (dmem_dout),
    .dmem_din     (dmem_din),
    .m_load_data  (m_load_data),
    .m_load_valid (m_load_valid),
    .m_misaligned (m_misaligned)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit mod_mis(input logic [2:0] f3,
                                 input logic [1:0] a);
    return (int'(a) % size_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] mod_ext(input logic [2:0] f3,
                                          input logic [1:0] a,
                                          input logic [31:0] w);
    int n;
    longint unsigned v;
    longint unsigned lim;
    n   = size_of(f3);
    lim = longint'(1) << (8 * n);
    v   = (longint'(w) >> (8 * int'(a))) % lim;
    if (n < 4 && !f3[2] && v >= lim / 2)
      v = v + (longint'(1) << 32) - lim;
    return v[31:0];
  endfunction

  function automatic logic [31:0] mod_din(input logic [2:0] f3,
                                          input logic [1:0] a,
                                          input logic [31:0] d);
    int n;
    longint unsigned v;
    n = size_of(f3);
    if (n == 4) return d;
    v = longint'(d) % (longint'(1) << (8 * n));
    if (n == 2) v = v << (16 * int'(a[1]));
    else        v = v << (8 * int'(a));
    return v[31:0];
  endfunction

  task automatic model_reset();
    mv = 0; mld = 0; mst = 0; mf3 = '0; ma = '0;
    hact = 0; hval = '0;
  endtask

  task automatic step(input bit v, input bit ld, input bit st,
                      input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] rs2, input logic [31:0] dout,
                      input bit stl, input bit fl);
    bit          emis, ev;
    logic [31:0] ed;
    @(negedge clk);
    ex_valid = v; ex_is_load = ld; ex_is_store = st;
    ex_funct3 = f3; ex_addr = a; ex_rs2_data = rs2;
    dmem_dout = dout; stall = stl; flush = fl;
    #1;
    emis = mod_mis(mf3, ma);
    ev   = mv && mld && !emis;
    ed   = !ev ? 32'h0 : (hact ? hval : mod_ext(mf3, ma, dout));
    chk("din", dmem_din, mod_din(f3, a[1:0], rs2));
    chk("ld_valid", {31'b0, m_load_valid}, {31'b0, ev});
    chk("misalign", {31'b0, m_misaligned},
        {31'b0, mv && (mld || mst) && emis});
    chk("ld_data", m_load_data, ed);
    last_data = m_load_data; last_din = dmem_din;
    last_valid = m_load_valid; last_mis = m_misaligned;
    @(posedge clk);
    if (!stl) begin
      mv = v && !fl; mld = ld; mst = st; mf3 = f3; ma = a[1:0];
      hact = 0;
    end else if (!hact && ev) begin
      hact = 1; hval = ed;
    end
  endtask

  task automatic nop(input logic [31:0] dout, input bit stl);
    step(0, 0, 0, 3'b000, 32'h0, 32'h0, dout, stl, 0);
  endtask

  initial begin
    rst_n = 0; stall = 0; flush = 0;
    ex_valid = 0; ex_is_load = 0; ex_is_store = 0;
    ex_funct3 = '0; ex_addr = '0; ex_rs2_data = '0;
    dmem_dout = 32'hFFFF_FFFF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, m_load_valid}, 32'h0);
    chk("rst_mis", {31'b0, m_misaligned}, 32'h0);
    chk("rst_data", m_load_data, 32'h0);
    @(negedge clk);
    rst_n = 1;
    nop(32'hFFFF_FFFF, 0);
    chk("post_rst_data", last_data, 32'h0);

    step(1, 1, 0, 3'b000, 32'h0000_1001, 0, 0, 0, 0);
    nop(32'h1234_8056, 0);
    chk("lb_data", last_data, 32'hFFFF_FF80);
    chk("lb_valid", {31'b0, last_valid}, 32'h1);

    step(1, 1, 0, 3'b101, 32'h0000_2002, 0, 0, 0, 0);
    step(1, 1, 0, 3'b001, 32'h0000_2002, 0, 32'h8001_0000, 0, 0);
    chk("lhu_data", last_data, 32'h0000_8001);
    nop(32'h8001_0000, 0);
    chk("lh_data", last_data, 32'hFFFF_8001);

    step(1, 0, 1, 3'b000, 32'h0000_0003, 32'h0000_00AB, 0, 0, 0);
    chk("sb_din", last_din, 32'hAB00_0000);
    step(1, 0, 1, 3'b001, 32'h0000_0002, 32'h0000_1234, 0, 0, 0);
    chk("sh_din", last_din, 32'h1234_0000);

    step(1, 1, 0, 3'b010, 32'h0000_0002, 0, 0, 0, 0);
    nop(32'h5555_5555, 0);
    chk("lw_mis", {31'b0, last_mis}, 32'h1);
    chk("lw_mis_data", last_data, 32'h0);

    step(1, 1, 0, 3'b010, 32'h0000_0010, 0, 0, 0, 0);
    nop(32'hDEAD_BEEF, 1);
    repeat (3) nop(32'h0, 1);
    chk("hold_data", last_data, 32'hDEAD_BEEF);
    chk("hold_valid", {31'b0, last_valid}, 32'h1);
    nop(32'h0, 0);

    step(1, 1, 0, 3'b010, 32'h0000_0020, 0, 0, 0, 1);
    nop(32'h1111_1111, 0);
    chk("flush_valid", {31'b0, last_valid}, 32'h0);

    step(1, 1, 0, 3'b010, 32'h0000_0030, 0, 0, 0, 0);
    nop(32'hCAFE_F00D, 1);
    @(negedge clk);
    stall = 1; ex_valid = 0; rst_n = 0;
    #1;
    chk("rst_stall_valid", {31'b0, m_load_valid}, 32'h0);
    chk("rst_stall_mis", {31'b0, m_misaligned}, 32'h0);
    chk("rst_stall_data", m_load_data, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    nop(32'hCAFE_F00D, 1);
    chk("rel_data", last_data, 32'h0);
    nop(32'hCAFE_F00D, 0);

    for (int i = 0; i < 400; i++) begin
      int k;
      k = $urandom_range(0, 2);
      step($urandom_range(0, 3) != 0, k == 1, k == 2,
           3'($urandom), $urandom, $urandom, $urandom,
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
